// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter and circular hardware return stack
//
// Purpose:
//    Holds the program counter and an 8-level circular return stack. The
//    instruction-cycle sequencer strobes en_pc and en_stack. On en_pc the
//    unit applies the next-PC operation. On en_stack it commits a return
//    address that an earlier CALL latched.
//
// Ports:
//    clock        in   system clock, rising edge
//    reset        in   synchronous active-high reset, beats every strobe
//    en_pc        in   one-cycle PC-update strobe
//    en_stack     in   one-cycle stack-commit strobe
//    pc_op        in   0 NEXT, 1 SKIP, 2 GOTO, 3 CALL, 4 RETURN,
//                      5 PCL_WRITE, 6/7 NEXT
//    k_addr       in   GOTO/CALL literal
//    pclath       in   PCLATH register value
//    pcl_wdata    in   data for PCL_WRITE
//    pc           out  current program counter
//    pcl          out  pc[7:0]
//    stack_depth  out  valid entries, saturating at STACK_DEPTH
//    push_pending out  CALL return address latched, awaiting en_stack
//    stk_ovf      out  pulse: push made while the stack was full
//    stk_unf      out  pulse: pop made while the stack was empty
//    push_lost    out  pulse: pending push discarded by a following en_pc

module pc_stack_unit #(
   parameter int                  PC_WIDTH     = 13,
   parameter int                  STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                en_pc,
   input  logic                en_stack,
   input  logic [2:0]          pc_op,
   input  logic [10:0]         k_addr,
   input  logic [4:0]          pclath,
   input  logic [7:0]          pcl_wdata,
   output logic [PC_WIDTH-1:0] pc,
   output logic [7:0]          pcl,
   output logic [3:0]          stack_depth,
   output logic                push_pending,
   output logic                stk_ovf,
   output logic                stk_unf,
   output logic                push_lost
);

   localparam int SPW = $clog2(STACK_DEPTH);

   localparam logic [2:0] OP_NEXT   = 3'd0;
   localparam logic [2:0] OP_SKIP   = 3'd1;
   localparam logic [2:0] OP_GOTO   = 3'd2;
   localparam logic [2:0] OP_CALL   = 3'd3;
   localparam logic [2:0] OP_RETURN = 3'd4;
   localparam logic [2:0] OP_PCLW   = 3'd5;

   localparam logic [3:0] DEPTH_FULL = 4'(STACK_DEPTH);

   // Registered state
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] r_ret_addr;
   logic [SPW-1:0]      r_sp;
   logic [3:0]          r_depth;
   logic                r_push_pending;
   logic                r_stk_ovf;
   logic                r_stk_unf;
   logic                r_push_lost;

   // Stack storage is never reset. After a wrap the oldest entry is
   // overwritten, and a pop past empty reads whatever is stored there.
   logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

   // Derived values
   logic [PC_WIDTH-1:0] w_pc_inc1;
   logic [PC_WIDTH-1:0] w_pc_inc2;
   logic [PC_WIDTH-1:0] w_goto_target;
   logic [PC_WIDTH-1:0] w_pclw_target;
   logic [SPW-1:0]      w_sp_inc;
   logic [SPW-1:0]      w_sp_dec;
   logic [PC_WIDTH-1:0] w_stack_top;
   logic [PC_WIDTH-1:0] w_pc_next;
   logic                w_arm_push;
   logic                w_pop;
   logic                w_push_commit;

   assign w_pc_inc1     = r_pc + PC_WIDTH'(1);
   assign w_pc_inc2     = r_pc + PC_WIDTH'(2);
   assign w_goto_target = PC_WIDTH'({pclath[4:3], k_addr});
   assign w_pclw_target = PC_WIDTH'({pclath, pcl_wdata});
   assign w_sp_inc      = r_sp + SPW'(1);
   assign w_sp_dec      = r_sp - SPW'(1);

   // The read port is combinational from the registered sp. A RETURN on
   // the cycle right after a push therefore sees the address just written.
   assign w_stack_top   = r_stack[w_sp_dec];

   // en_pc has priority. A push commits only on a lone en_stack while a
   // CALL is pending.
   assign w_push_commit = !reset && !en_pc && en_stack && r_push_pending;

   // Next-PC selection. The result is used only when en_pc is high.
   always_comb begin
      w_pc_next  = w_pc_inc1;
      w_arm_push = 1'b0;
      w_pop      = 1'b0;
      case (pc_op)
         OP_NEXT:   w_pc_next = w_pc_inc1;
         OP_SKIP:   w_pc_next = w_pc_inc2;
         OP_GOTO:   w_pc_next = w_goto_target;
         OP_CALL: begin
            w_pc_next  = w_goto_target;
            w_arm_push = 1'b1;
         end
         OP_RETURN: begin
            w_pc_next = w_stack_top;
            w_pop     = 1'b1;
         end
         OP_PCLW:   w_pc_next = w_pclw_target;
         default:   w_pc_next = w_pc_inc1;
      endcase
   end

   // PC, stack pointer, depth and pulse registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc           <= RESET_VECTOR;
         r_ret_addr     <= '0;
         r_sp           <= '0;
         r_depth        <= '0;
         r_push_pending <= 1'b0;
         r_stk_ovf      <= 1'b0;
         r_stk_unf      <= 1'b0;
         r_push_lost    <= 1'b0;
      end else begin
         r_stk_ovf   <= 1'b0;
         r_stk_unf   <= 1'b0;
         r_push_lost <= 1'b0;

         if (en_pc) begin
            r_pc <= w_pc_next;
            // A still-pending push here means the sequencer dropped its
            // en_stack. Discard the push. A new CALL can re-arm it below.
            r_push_lost    <= r_push_pending;
            r_push_pending <= w_arm_push;
            if (w_arm_push) begin
               r_ret_addr <= w_pc_inc1;
            end
            if (w_pop) begin
               r_sp <= w_sp_dec;
               if (r_depth == 4'd0) begin
                  r_stk_unf <= 1'b1;
               end else begin
                  r_depth <= r_depth - 4'd1;
               end
            end
         end else if (en_stack && r_push_pending) begin
            r_sp           <= w_sp_inc;
            r_push_pending <= 1'b0;
            if (r_depth == DEPTH_FULL) begin
               r_stk_ovf <= 1'b1;
            end else begin
               r_depth <= r_depth + 4'd1;
            end
         end
      end
   end

   // Stack write port
   always_ff @(posedge clock) begin
      if (w_push_commit) begin
         r_stack[r_sp] <= r_ret_addr;
      end
   end

   assign pc           = r_pc;
   assign pcl          = r_pc[7:0];
   assign stack_depth  = r_depth;
   assign push_pending = r_push_pending;
   assign stk_ovf      = r_stk_ovf;
   assign stk_unf      = r_stk_unf;
   assign push_lost    = r_push_lost;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit

module tb_pc_stack_unit;

   logic        clock;
   logic        reset;
   logic        en_pc;
   logic        en_stack;
   logic [2:0]  pc_op;
   logic [10:0] k_addr;
   logic [4:0]  pclath;
   logic [7:0]  pcl_wdata;
   logic [12:0] pc;
   logic [7:0]  pcl;
   logic [3:0]  stack_depth;
   logic        push_pending;
   logic        stk_ovf;
   logic        stk_unf;
   logic        push_lost;

   int n_vec;
   int n_err;

   pc_stack_unit dut (
      .clock        (clock),
      .reset        (reset),
      .en_pc        (en_pc),
      .en_stack     (en_stack),
      .pc_op        (pc_op),
      .k_addr       (k_addr),
      .pclath       (pclath),
      .pcl_wdata    (pcl_wdata),
      .pc           (pc),
      .pcl          (pcl),
      .stack_depth  (stack_depth),
      .push_pending (push_pending),
      .stk_ovf      (stk_ovf),
      .stk_unf      (stk_unf),
      .push_lost    (push_lost)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stimulus drivers. Inputs change 1 ns after a rising edge, and outputs
   // are sampled at that same point.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic do_pc(input logic [2:0] op, input logic [10:0] k,
                        input logic [4:0] lath, input logic [7:0] wd);
      en_pc = 1'b1; pc_op = op; k_addr = k; pclath = lath; pcl_wdata = wd;
      @(posedge clock); #1;
      en_pc = 1'b0;
   endtask

   task automatic do_stack();
      en_stack = 1'b1;
      @(posedge clock); #1;
      en_stack = 1'b0;
   endtask

   task automatic do_idle();
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (pc !== 13'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", pc); end
      n_vec++; if (stack_depth !== 4'd0) begin n_err++; $display("FAIL reset_depth: got %0d want 0", stack_depth); end
      n_vec++; if (push_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", push_pending); end
      n_vec++; if ({stk_ovf, stk_unf, push_lost} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {stk_ovf, stk_unf, push_lost}); end
   endtask

   task automatic test_next_skip();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         do_pc(3'd0, 11'h0, 5'h0, 8'h0);
         n_vec++; if (pc !== 13'(i)) begin n_err++; $display("FAIL next_%0d: got %h want %h", i, pc, 13'(i)); end
      end
      do_idle(); do_idle();
      n_vec++; if (pc !== 13'h0003) begin n_err++; $display("FAIL hold: got %h want 0003", pc); end
      do_pc(3'd7, 11'h0, 5'h0, 8'h0);
      n_vec++; if (pc !== 13'h0004) begin n_err++; $display("FAIL op7_next: got %h want 0004", pc); end
      do_pc(3'd5, 11'h0, 5'h1F, 8'hFF);
      n_vec++; if (pc !== 13'h1FFF) begin n_err++; $display("FAIL pclw_max: got %h want 1fff", pc); end
      do_pc(3'd1, 11'h0, 5'h0, 8'h0);
      n_vec++; if (pc !== 13'h0001) begin n_err++; $display("FAIL skip_wrap: got %h want 0001", pc); end
      do_pc(3'd5, 11'h0, 5'h1F, 8'hFF);
      do_pc(3'd0, 11'h0, 5'h0, 8'h0);
      n_vec++; if (pc !== 13'h0000) begin n_err++; $display("FAIL next_wrap: got %h want 0000", pc); end
   endtask

   task automatic test_call_return();
      do_reset();
      do_pc(3'd2, 11'h040, 5'h00, 8'h0);
      n_vec++; if (pc !== 13'h0040) begin n_err++; $display("FAIL goto_40: got %h want 0040", pc); end
      do_pc(3'd3, 11'h123, 5'h18, 8'h0);
      n_vec++; if (pc !== 13'h1923) begin n_err++; $display("FAIL call_target: got %h want 1923", pc); end
      n_vec++; if (push_pending !== 1'b1) begin n_err++; $display("FAIL call_pending: got %b want 1", push_pending); end
      n_vec++; if (stack_depth !== 4'd0) begin n_err++; $display("FAIL call_depth0: got %0d want 0", stack_depth); end
      do_stack();
      n_vec++; if (stack_depth !== 4'd1) begin n_err++; $display("FAIL push_depth: got %0d want 1", stack_depth); end
      n_vec++; if (push_pending !== 1'b0) begin n_err++; $display("FAIL push_cleared: got %b want 0", push_pending); end
      do_stack();
      n_vec++; if (stack_depth !== 4'd1) begin n_err++; $display("FAIL stack_noop: got %0d want 1", stack_depth); end
      do_pc(3'd0, 11'h0, 5'h0, 8'h0);
      do_pc(3'd4, 11'h0, 5'h0, 8'h0);
      n_vec++; if (pc !== 13'h0041) begin n_err++; $display("FAIL return_pc: got %h want 0041", pc); end
      n_vec++; if (stack_depth !== 4'd0) begin n_err++; $display("FAIL return_depth: got %0d want 0", stack_depth); end
      n_vec++; if (stk_unf !== 1'b0) begin n_err++; $display("FAIL return_unf: got %b want 0", stk_unf); end
   endtask

   task automatic test_nested();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         do_pc(3'd2, 11'(8'h10 + i), 5'h00, 8'h0);
         do_pc(3'd3, 11'h200, 5'h00, 8'h0);
         do_stack();
         n_vec++; if (stack_depth !== 4'((i < 8) ? i + 1 : 8)) begin n_err++; $display("FAIL nest_depth_%0d: got %0d want %0d", i, stack_depth, (i < 8) ? i + 1 : 8); end
         n_vec++; if (stk_ovf !== (i == 8)) begin n_err++; $display("FAIL nest_ovf_%0d: got %b want %b", i, stk_ovf, (i == 8)); end
      end
      do_idle();
      n_vec++; if (stk_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle: got %b want 0", stk_ovf); end
      for (int j = 0; j < 8; j++) begin
         do_pc(3'd4, 11'h0, 5'h0, 8'h0);
         n_vec++; if (pc !== 13'(8'h19 - j)) begin n_err++; $display("FAIL ret_pc_%0d: got %h want %h", j, pc, 13'(8'h19 - j)); end
         n_vec++; if (stack_depth !== 4'(7 - j)) begin n_err++; $display("FAIL ret_depth_%0d: got %0d want %0d", j, stack_depth, 7 - j); end
         n_vec++; if (stk_unf !== 1'b0) begin n_err++; $display("FAIL ret_unf_%0d: got %b want 0", j, stk_unf); end
      end
      do_pc(3'd4, 11'h0, 5'h0, 8'h0);
      n_vec++; if (stk_unf !== 1'b1) begin n_err++; $display("FAIL underflow: got %b want 1", stk_unf); end
      n_vec++; if (stack_depth !== 4'd0) begin n_err++; $display("FAIL unf_depth: got %0d want 0", stack_depth); end
      n_vec++; if (pc !== 13'h0019) begin n_err++; $display("FAIL unf_wrap_pc: got %h want 0019", pc); end
      do_idle();
      n_vec++; if (stk_unf !== 1'b0) begin n_err++; $display("FAIL unf_one_cycle: got %b want 0", stk_unf); end
   endtask

   task automatic test_push_lost();
      do_reset();
      do_pc(3'd2, 11'h050, 5'h00, 8'h0);
      do_pc(3'd3, 11'h300, 5'h00, 8'h0);
      do_pc(3'd0, 11'h0, 5'h0, 8'h0);
      n_vec++; if (push_lost !== 1'b1) begin n_err++; $display("FAIL lost_pulse: got %b want 1", push_lost); end
      n_vec++; if (pc !== 13'h0301) begin n_err++; $display("FAIL lost_pc: got %h want 0301", pc); end
      n_vec++; if (push_pending !== 1'b0) begin n_err++; $display("FAIL lost_pending: got %b want 0", push_pending); end
      do_stack();
      n_vec++; if (push_lost !== 1'b0) begin n_err++; $display("FAIL lost_one_cycle: got %b want 0", push_lost); end
      n_vec++; if (stack_depth !== 4'd0) begin n_err++; $display("FAIL lost_depth: got %0d want 0", stack_depth); end
      // A CALL that overrides a pending CALL re-arms with its own return address.
      do_pc(3'd3, 11'h080, 5'h00, 8'h0);
      do_pc(3'd3, 11'h0A0, 5'h00, 8'h0);
      n_vec++; if ({push_lost, push_pending} !== 2'b11) begin n_err++; $display("FAIL rearm: got %b want 11", {push_lost, push_pending}); end
      do_stack();
      do_pc(3'd4, 11'h0, 5'h0, 8'h0);
      n_vec++; if (pc !== 13'h0081) begin n_err++; $display("FAIL rearm_ret: got %h want 0081", pc); end
   endtask

   task automatic test_pcl_write();
      do_reset();
      do_pc(3'd5, 11'h7FF, 5'h03, 8'hA5);
      n_vec++; if (pc !== 13'h03A5) begin n_err++; $display("FAIL pclw_pc: got %h want 03a5", pc); end
      n_vec++; if (pcl !== 8'hA5) begin n_err++; $display("FAIL pclw_pcl: got %h want a5", pcl); end
   endtask

   task automatic test_both_strobes();
      do_reset();
      do_pc(3'd3, 11'h100, 5'h00, 8'h0);
      en_stack = 1'b1;
      do_pc(3'd0, 11'h0, 5'h0, 8'h0);
      en_stack = 1'b0;
      n_vec++; if (push_lost !== 1'b1) begin n_err++; $display("FAIL both_lost: got %b want 1", push_lost); end
      n_vec++; if (stack_depth !== 4'd0) begin n_err++; $display("FAIL both_depth: got %0d want 0", stack_depth); end
      n_vec++; if (pc !== 13'h0101) begin n_err++; $display("FAIL both_pc: got %h want 0101", pc); end
      n_vec++; if (push_pending !== 1'b0) begin n_err++; $display("FAIL both_pending: got %b want 0", push_pending); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_pc(3'd2, 11'h070, 5'h00, 8'h0);
      do_pc(3'd3, 11'h400, 5'h00, 8'h0);
      do_stack();
      do_pc(3'd4, 11'h0, 5'h0, 8'h0);
      n_vec++; if (pc !== 13'h0071) begin n_err++; $display("FAIL b2b_ret: got %h want 0071", pc); end
   endtask

   task automatic test_reset_mid_call();
      do_reset();
      do_pc(3'd2, 11'h020, 5'h00, 8'h0);
      do_pc(3'd3, 11'h100, 5'h00, 8'h0);
      do_reset();
      n_vec++; if (pc !== 13'h0000) begin n_err++; $display("FAIL rmid_pc: got %h want 0000", pc); end
      n_vec++; if ({stack_depth, push_pending} !== 5'b0) begin n_err++; $display("FAIL rmid_state: got %b want 00000", {stack_depth, push_pending}); end
      n_vec++; if ({stk_ovf, stk_unf, push_lost} !== 3'b000) begin n_err++; $display("FAIL rmid_pulses: got %b want 000", {stk_ovf, stk_unf, push_lost}); end
      do_stack();
      n_vec++; if ({stack_depth, push_lost} !== 5'b0) begin n_err++; $display("FAIL rmid_after: got %b want 00000", {stack_depth, push_lost}); end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b1; en_pc = 1'b0; en_stack = 1'b0;
      pc_op = 3'd0; k_addr = '0; pclath = '0; pcl_wdata = '0;
      @(posedge clock); #1;
      test_reset();
      test_next_skip();
      test_call_return();
      test_nested();
      test_push_lost();
      test_pcl_write();
      test_both_strobes();
      test_back_to_back();
      test_reset_mid_call();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
